// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Multi-port integer register file with optional write-to-read
//            bypass, per-register busy scoreboard and write-collision flag.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_mp #(
  parameter int XLEN      = 32,
  parameter int NREGS     = 32,
  parameter int NRD       = 2,
  parameter int NWR       = 2,
  parameter bit BYPASS    = 1'b1,
  parameter int INIT_MODE = 1,
  localparam int AW       = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR*XLEN-1:0] wr_data,
  input  logic                sb_set_en,
  input  logic [AW-1:0]       sb_set_addr,
  output logic [NREGS-1:0]    sb_busy,
  output logic                wr_collision
);

  if ((NREGS < 2) || ((NREGS & (NREGS - 1)) != 0)) begin : g_bad_nregs
    $error("regfile_mp: NREGS must be a power of two >= 2");
  end
  if ((NRD < 1) || (NRD > 4)) begin : g_bad_nrd
    $error("regfile_mp: NRD must be in 1..4");
  end
  if ((NWR < 1) || (NWR > 2)) begin : g_bad_nwr
    $error("regfile_mp: NWR must be in 1..2");
  end

  function automatic logic [XLEN-1:0] init_val(input int idx);
    int prod;
    prod = idx * 10;
    if (INIT_MODE == 1) return XLEN'(prod);
    return '0;
  endfunction

  logic [XLEN-1:0]  regs_q [NREGS];
  logic [XLEN-1:0]  regs_d [NREGS];
  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;
  logic             coll_q;
  logic             coll_d;

  logic [AW-1:0]    w_wr_addr [NWR];
  logic [XLEN-1:0]  w_wr_data [NWR];
  logic [NWR-1:0]   w_wr_act;

  // A write only counts when it targets a real (nonzero) register.
  for (genvar p = 0; p < NWR; p++) begin : g_wr_unpack
    assign w_wr_addr[p] = wr_addr[p*AW +: AW];
    assign w_wr_data[p] = wr_data[p*XLEN +: XLEN];
    assign w_wr_act[p]  = wr_en[p] && (w_wr_addr[p] != '0);
  end

  if (NWR == 2) begin : g_coll
    assign coll_d = w_wr_act[0] && w_wr_act[1] && (w_wr_addr[0] == w_wr_addr[1]);
  end else begin : g_no_coll
    assign coll_d = 1'b0;
  end

  // Ascending port order makes the highest-index port win a collision; the
  // scoreboard set is applied after the clears so a new producer stays busy.
  always_comb begin
    for (int i = 0; i < NREGS; i++) regs_d[i] = regs_q[i];
    busy_d = busy_q;
    for (int p = 0; p < NWR; p++) begin
      if (w_wr_act[p]) begin
        regs_d[w_wr_addr[p]] = w_wr_data[p];
        busy_d[w_wr_addr[p]] = 1'b0;
      end
    end
    if (sb_set_en && (sb_set_addr != '0)) busy_d[sb_set_addr] = 1'b1;
    busy_d[0] = 1'b0;
    regs_d[0] = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= init_val(i);
      busy_q <= '0;
      coll_q <= 1'b0;
    end else begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= regs_d[i];
      busy_q <= busy_d;
      coll_q <= coll_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_val;

    assign w_ra = rd_addr[k*AW +: AW];

    always_comb begin
      w_val = regs_q[w_ra];
      if (BYPASS) begin
        for (int p = 0; p < NWR; p++) begin
          if (w_wr_act[p] && (w_wr_addr[p] == w_ra)) w_val = w_wr_data[p];
        end
      end
      if (w_ra == '0) w_val = '0;
    end

    assign rd_data[k*XLEN +: XLEN] = w_val;
  end

  assign sb_busy      = busy_q;
  assign wr_collision = coll_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Self-checking bench for regfile_mp (bypass and non-bypass
//            instances sharing one stimulus stream and one reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_mp;

  logic         clk;
  logic         rst;
  logic [19:0]  rd_addr;
  logic [127:0] rd_data;
  logic [127:0] rd_data_nb;
  logic [1:0]   wr_en;
  logic [9:0]   wr_addr;
  logic [63:0]  wr_data;
  logic         sb_set_en;
  logic [4:0]   sb_set_addr;
  logic [31:0]  sb_busy;
  logic [31:0]  sb_busy_nb;
  logic         wr_collision;
  logic         wr_collision_nb;

  int n_chk  = 0;
  int n_fail = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy;
  logic        m_coll;

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .BYPASS(1'b1), .INIT_MODE(1)) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .sb_busy(sb_busy), .wr_collision(wr_collision)
  );

  regfile_mp #(.XLEN(32), .NREGS(32), .NRD(4), .NWR(2), .BYPASS(1'b0), .INIT_MODE(1)) dut_nb (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .sb_busy(sb_busy_nb), .wr_collision(wr_collision_nb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value given the model state and the inputs now on the pins.
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 5'd0) return 32'd0;
    if (byp) begin
      if (wr_en[1] && wr_addr[9:5] == a) return wr_data[63:32];
      if (wr_en[0] && wr_addr[4:0] == a) return wr_data[31:0];
    end
    return m_regs[a];
  endfunction

  task automatic apply_edge();
    logic [4:0] a;
    if (!rst) begin
      for (int i = 0; i < 32; i++) m_regs[i] = i * 10;
      m_busy = 32'd0;
      m_coll = 1'b0;
    end else begin
      m_coll = (wr_en == 2'b11) && (wr_addr[4:0] == wr_addr[9:5]) && (wr_addr[4:0] != 5'd0);
      for (int p = 0; p < 2; p++) begin
        a = wr_addr[p*5 +: 5];
        if (wr_en[p] && a != 5'd0) begin
          m_regs[a] = wr_data[p*32 +: 32];
          m_busy[a] = 1'b0;
        end
      end
      if (sb_set_en && sb_set_addr != 5'd0) m_busy[sb_set_addr] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    apply_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b1; wr_en = 2'b00; wr_addr = '0; wr_data = '0;
    sb_set_en = 1'b0; sb_set_addr = '0;
  endtask

  task automatic set_rd(input logic [4:0] a0, a1, a2, a3);
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic drive_wr(input logic [1:0] en, input logic [4:0] a0, a1,
                          input logic [31:0] d0, d1);
    wr_en = en; wr_addr = {a1, a0}; wr_data = {d1, d0};
  endtask

  task automatic test_reset();
    idle(); rst = 1'b0;
    tick();
    idle(); set_rd(5'd0, 5'd1, 5'd3, 5'd31);
    #1;
    n_chk++; if (rd_data[31:0] !== 32'd0) begin n_fail++; $display("FAIL reset_x0: got %h want %h", rd_data[31:0], 32'd0); end
    n_chk++; if (rd_data[63:32] !== 32'd10) begin n_fail++; $display("FAIL reset_x1: got %h want %h", rd_data[63:32], 32'd10); end
    n_chk++; if (rd_data[95:64] !== 32'd30) begin n_fail++; $display("FAIL reset_x3: got %h want %h", rd_data[95:64], 32'd30); end
    n_chk++; if (rd_data[127:96] !== 32'd310) begin n_fail++; $display("FAIL reset_x31: got %h want %h", rd_data[127:96], 32'd310); end
    n_chk++; if (rd_data_nb[95:64] !== 32'd30) begin n_fail++; $display("FAIL reset_x3_nb: got %h want %h", rd_data_nb[95:64], 32'd30); end
    n_chk++; if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL reset_busy: got %h want %h", sb_busy, 32'd0); end
    n_chk++; if (wr_collision !== 1'b0) begin n_fail++; $display("FAIL reset_coll: got %b want 0", wr_collision); end
  endtask

  task automatic test_write();
    idle(); drive_wr(2'b00, 5'd3, 5'd0, 32'hDEADBEEF, 32'd0);
    tick();
    idle(); set_rd(5'd3, 5'd0, 5'd0, 5'd0);
    #1;
    n_chk++; if (rd_data[31:0] !== 32'd30) begin n_fail++; $display("FAIL wr_disabled: got %h want %h", rd_data[31:0], 32'd30); end
    drive_wr(2'b01, 5'd2, 5'd0, 32'h11112222, 32'd0);
    set_rd(5'd2, 5'd1, 5'd0, 5'd0);
    #1;
    n_chk++; if (rd_data[31:0] !== 32'h11112222) begin n_fail++; $display("FAIL wr_bypass: got %h want %h", rd_data[31:0], 32'h11112222); end
    n_chk++; if (rd_data_nb[31:0] !== 32'd20) begin n_fail++; $display("FAIL wr_nobypass: got %h want %h", rd_data_nb[31:0], 32'd20); end
    tick();
    idle(); #1;
    n_chk++; if (rd_data[31:0] !== 32'h11112222) begin n_fail++; $display("FAIL wr_stored: got %h want %h", rd_data[31:0], 32'h11112222); end
    n_chk++; if (rd_data_nb[31:0] !== 32'h11112222) begin n_fail++; $display("FAIL wr_stored_nb: got %h want %h", rd_data_nb[31:0], 32'h11112222); end
    n_chk++; if (rd_data[63:32] !== 32'd10) begin n_fail++; $display("FAIL wr_other: got %h want %h", rd_data[63:32], 32'd10); end
  endtask

  task automatic test_collision();
    idle(); drive_wr(2'b11, 5'd5, 5'd5, 32'hAAAA0000, 32'hBBBB0000);
    set_rd(5'd5, 5'd5, 5'd0, 5'd0);
    #1;
    n_chk++; if (rd_data[31:0] !== 32'hBBBB0000) begin n_fail++; $display("FAIL coll_bypass: got %h want %h", rd_data[31:0], 32'hBBBB0000); end
    n_chk++; if (rd_data_nb[31:0] !== 32'd50) begin n_fail++; $display("FAIL coll_nobypass: got %h want %h", rd_data_nb[31:0], 32'd50); end
    tick();
    idle(); #1;
    n_chk++; if (rd_data_nb[31:0] !== 32'hBBBB0000) begin n_fail++; $display("FAIL coll_winner: got %h want %h", rd_data_nb[31:0], 32'hBBBB0000); end
    n_chk++; if (wr_collision !== 1'b1) begin n_fail++; $display("FAIL coll_flag: got %b want 1", wr_collision); end
    tick();
    n_chk++; if (wr_collision !== 1'b0) begin n_fail++; $display("FAIL coll_one_cycle: got %b want 0", wr_collision); end
    drive_wr(2'b11, 5'd0, 5'd0, 32'hFFFFFFFF, 32'h12121212);
    set_rd(5'd0, 5'd0, 5'd0, 5'd0);
    #1;
    n_chk++; if (rd_data[31:0] !== 32'd0) begin n_fail++; $display("FAIL coll_x0_read: got %h want 0", rd_data[31:0]); end
    tick();
    idle(); #1;
    n_chk++; if (wr_collision !== 1'b0) begin n_fail++; $display("FAIL coll_x0_flag: got %b want 0", wr_collision); end
    n_chk++; if (rd_data_nb[31:0] !== 32'd0) begin n_fail++; $display("FAIL coll_x0_stored: got %h want 0", rd_data_nb[31:0]); end
  endtask

  task automatic test_scoreboard();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd7;
    tick();
    n_chk++; if (sb_busy[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set: got %b want 1", sb_busy[7]); end
    drive_wr(2'b01, 5'd7, 5'd0, 32'h77, 32'd0);
    tick();
    n_chk++; if (sb_busy[7] !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins: got %b want 1", sb_busy[7]); end
    idle(); drive_wr(2'b10, 5'd0, 5'd7, 32'd0, 32'h78);
    tick();
    n_chk++; if (sb_busy[7] !== 1'b0) begin n_fail++; $display("FAIL sb_clear: got %b want 0", sb_busy[7]); end
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd0;
    tick();
    idle();
    n_chk++; if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL sb_x0: got %h want %h", sb_busy, 32'd0); end
  endtask

  task automatic test_mid_reset();
    idle(); sb_set_en = 1'b1; sb_set_addr = 5'd9;
    tick();
    idle(); rst = 1'b0;
    drive_wr(2'b01, 5'd4, 5'd0, 32'h12345678, 32'd0);
    sb_set_en = 1'b1; sb_set_addr = 5'd4;
    tick();
    idle(); set_rd(5'd4, 5'd2, 5'd0, 5'd0);
    #1;
    n_chk++; if (rd_data[31:0] !== 32'd40) begin n_fail++; $display("FAIL mid_reset_x4: got %h want %h", rd_data[31:0], 32'd40); end
    n_chk++; if (rd_data[63:32] !== 32'd20) begin n_fail++; $display("FAIL mid_reset_x2: got %h want %h", rd_data[63:32], 32'd20); end
    n_chk++; if (sb_busy !== 32'd0) begin n_fail++; $display("FAIL mid_reset_busy: got %h want %h", sb_busy, 32'd0); end
  endtask

  task automatic test_all_ports_bypass();
    idle(); drive_wr(2'b10, 5'd0, 5'd9, 32'd0, 32'h0F0F0F0F);
    set_rd(5'd9, 5'd9, 5'd9, 5'd9);
    #1;
    for (int k = 0; k < 4; k++) begin
      n_chk++;
      if (rd_data[k*32 +: 32] !== 32'h0F0F0F0F) begin
        n_fail++; $display("FAIL allports_byp%0d: got %h want %h", k, rd_data[k*32 +: 32], 32'h0F0F0F0F);
      end
      n_chk++;
      if (rd_data_nb[k*32 +: 32] !== 32'd90) begin
        n_fail++; $display("FAIL allports_nb%0d: got %h want %h", k, rd_data_nb[k*32 +: 32], 32'd90);
      end
    end
    tick();
    idle();
  endtask

  // Small address range most of the time so collisions and bypass hits occur.
  function automatic logic [4:0] rnd_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [31:0] e;
    logic [4:0]  a;
    for (int c = 0; c < 400; c++) begin
      rst         = ($urandom_range(0, 59) != 0);
      drive_wr(2'($urandom), rnd_addr(), rnd_addr(), $urandom, $urandom);
      sb_set_en   = 1'($urandom);
      sb_set_addr = rnd_addr();
      set_rd(rnd_addr(), wr_addr[4:0], wr_addr[9:5], rnd_addr());
      #1;
      for (int k = 0; k < 4; k++) begin
        a = rd_addr[k*5 +: 5];
        e = exp_rd(a, 1'b1);
        n_chk++;
        if (rd_data[k*32 +: 32] !== e) begin
          n_fail++; $display("FAIL rnd_rd cyc%0d port%0d x%0d: got %h want %h", c, k, a, rd_data[k*32 +: 32], e);
        end
        e = exp_rd(a, 1'b0);
        n_chk++;
        if (rd_data_nb[k*32 +: 32] !== e) begin
          n_fail++; $display("FAIL rnd_rd_nb cyc%0d port%0d x%0d: got %h want %h", c, k, a, rd_data_nb[k*32 +: 32], e);
        end
      end
      tick();
      n_chk++; if (sb_busy !== m_busy) begin n_fail++; $display("FAIL rnd_busy cyc%0d: got %h want %h", c, sb_busy, m_busy); end
      n_chk++; if (sb_busy_nb !== m_busy) begin n_fail++; $display("FAIL rnd_busy_nb cyc%0d: got %h want %h", c, sb_busy_nb, m_busy); end
      n_chk++; if (wr_collision !== m_coll) begin n_fail++; $display("FAIL rnd_coll cyc%0d: got %b want %b", c, wr_collision, m_coll); end
      n_chk++; if (wr_collision_nb !== m_coll) begin n_fail++; $display("FAIL rnd_coll_nb cyc%0d: got %b want %b", c, wr_collision_nb, m_coll); end
    end
    idle();
  endtask

  initial begin
    idle(); rst = 1'b0; rd_addr = '0;
    @(negedge clk);
    test_reset();
    test_write();
    test_collision();
    test_scoreboard();
    test_mid_reset();
    test_all_ports_bypass();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
